// File: rtl/maxpool_2x2_stream_if.sv
// Streaming handshake bundle for maxpool_2x2_stream.
//   in_valid/in_data/in_ready    : upstream samples, raster order
//   out_valid/out_data/out_ready : downstream pooled maxima
// Modports: slave = the pooling block, master = the environment driving it.
interface maxpool_2x2_stream_if #(
   parameter int unsigned DATA_W = 32
);
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_ready;
   logic                     out_valid;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// 2x2 / stride-2 max pooling over a MAP_H x MAP_W signed feature map streamed in
// raster order; emits (MAP_H/2) x (MAP_W/2) maxima in raster order.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : begin one frame (only honoured when idle)
//   busy     : high whenever not idle
//   done     : one-cycle pulse when the frame has fully drained
//   bus      : input/output valid-ready streams (slave side)
module maxpool_2x2_stream #(
   parameter int unsigned MAP_W  = 6,
   parameter int unsigned MAP_H  = 6,
   parameter int unsigned DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   maxpool_2x2_stream_if.slave  bus
);
   localparam int unsigned HalfW = MAP_W / 2;
   localparam int unsigned ColW  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
   localparam int unsigned RowW  = (MAP_H > 1) ? $clog2(MAP_H) : 1;
   localparam int unsigned IdxW  = (HalfW > 1) ? $clog2(HalfW) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StFin} state_e;

   state_e                   state_q, state_d;
   logic [ColW-1:0]          col_q, col_d;
   logic [RowW-1:0]          row_q, row_d;
   logic signed [DATA_W-1:0] h_q, h_d;
   logic signed [DATA_W-1:0] part_q [HalfW];
   logic signed [DATA_W-1:0] part_d [HalfW];
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] out_data_q, out_data_d;

   logic                     in_ready;
   logic                     accept;
   logic                     last_col;
   logic                     last_row;
   logic [IdxW-1:0]          idx;
   logic signed [DATA_W-1:0] hmax;
   logic signed [DATA_W-1:0] pooled;

   // Input stalls only while a result is stuck downstream; a draining result
   // frees the slot on the same edge, so input may be taken then.
   assign in_ready = (state_q == StRun) && !(out_valid_q && !bus.out_ready);
   assign accept   = bus.in_valid && in_ready;
   assign last_col = (col_q == ColW'(MAP_W - 1));
   assign last_row = (row_q == RowW'(MAP_H - 1));
   assign idx      = IdxW'(col_q >> 1);
   assign hmax     = (bus.in_data > h_q) ? bus.in_data : h_q;
   assign pooled   = (hmax > part_q[idx]) ? hmax : part_q[idx];

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StFin);

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      h_d         = h_q;
      part_d      = part_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (!col_q[0]) begin
            h_d = bus.in_data;
         end else if (!row_q[0]) begin
            part_d[idx] = hmax;
         end else begin
            // A load here wins over the clear above: no bubble on back-to-back.
            out_data_d  = pooled;
            out_valid_d = 1'b1;
         end

         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               col_d   = '0;
               row_d   = '0;
            end
         end
         StRun: begin
            if (accept && last_col && last_row) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if (!out_valid_q) begin
               state_d = StFin;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         col_q       <= '0;
         row_q       <= '0;
         h_q         <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int i = 0; i < HalfW; i++) begin
            part_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         h_q         <= h_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         for (int i = 0; i < HalfW; i++) begin
            part_q[i] <= part_d[i];
         end
      end
   end
endmodule
